// File: rtl/apb_pkg.sv
// Shared APB definitions: state encoding (common with the APB slave memory),
// default bus widths and the wait-timer counter width.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SETUP  = 2'b01,
        ACCESS = 2'b10
    } apb_state_e;

    localparam int unsigned APB_ADDR_W = 32;
    localparam int unsigned APB_DATA_W = 32;
    localparam int unsigned APB_TMO_W  = 8;

endpackage

// File: rtl/apb_master_bridge_if.sv
// Local command/response channel plus APB requester signals.
// The master modport is the bridge; the slave modport is its environment.
interface apb_master_bridge_if
    import apb_pkg::*;
#(
    parameter int unsigned ADDR_W = APB_ADDR_W,
    parameter int unsigned DATA_W = APB_DATA_W
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic [ADDR_W-1:0] Paddr;
    logic              Pselx;
    logic              Penable;
    logic              Pwrite;
    logic [DATA_W-1:0] Pwdata;
    logic              Pready;
    logic [DATA_W-1:0] Prdata;
    logic              Pslverr;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, Pready, Prdata, Pslverr,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
        output Paddr, Pselx, Penable, Pwrite, Pwdata
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, Pready, Prdata, Pslverr,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
        input  Paddr, Pselx, Penable, Pwrite, Pwdata
    );

endinterface

// File: rtl/apb_wait_timer.sv
// ACCESS wait-state counter; present only when APB_TIMEOUT_EN is defined.
// Expires on the count_en cycle that brings the count up to limit.
`ifdef APB_TIMEOUT_EN
module apb_wait_timer
    import apb_pkg::*;
(
    input  logic                 Pclk,
    input  logic                 Prst,
    input  logic                 i_clear,
    input  logic                 i_count_en,
    input  logic [APB_TMO_W-1:0] i_limit,
    output logic                 o_expired
);
    logic [APB_TMO_W-1:0] r_count;

    always_ff @(posedge Pclk) begin
        if (Prst || i_clear) begin
            r_count <= '0;
        end else if (i_count_en) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_expired = i_count_en && (r_count == (i_limit - 8'd1));

endmodule
`endif

// File: rtl/apb_master_bridge.sv
// APB requester: turns local commands into IDLE/SETUP/ACCESS transfers and
// returns one response per command. Optional wait-state timeout: APB_TIMEOUT_EN.
module apb_master_bridge
    import apb_pkg::*;
#(
    parameter int unsigned ADDR_W         = APB_ADDR_W,
    parameter int unsigned DATA_W         = APB_DATA_W,
    parameter int unsigned TIMEOUT_CYCLES = 16
)(
    input  logic                Pclk,
    input  logic                Prst,
    apb_master_bridge_if.master bus
);

    apb_state_e        r_state;
    apb_state_e        w_next_state;
    logic [ADDR_W-1:0] r_paddr;
    logic [DATA_W-1:0] r_pwdata;
    logic [DATA_W-1:0] r_rsp_rdata;
    logic              r_pwrite;
    logic              r_pselx;
    logic              r_penable;
    logic              r_rsp_valid;
    logic              r_rsp_err;
    logic              w_cmd_ready;
    logic              w_cmd_accept;
    logic              w_xfer_done;
    logic              w_timeout;
    logic              w_expired;

`ifdef APB_TIMEOUT_EN
    localparam logic [APB_TMO_W-1:0] TMO_LIMIT = APB_TMO_W'(TIMEOUT_CYCLES);
    logic w_tmr_clear;
    logic w_tmr_count;

    assign w_tmr_clear = (r_state == SETUP);
    assign w_tmr_count = (r_state == ACCESS) && !bus.Pready;

    apb_wait_timer u_wait_timer (
        .Pclk       (Pclk),
        .Prst       (Prst),
        .i_clear    (w_tmr_clear),
        .i_count_en (w_tmr_count),
        .i_limit    (TMO_LIMIT),
        .o_expired  (w_expired)
    );
`else
    assign w_expired = 1'b0;
`endif

    // NOTE: every output below is assigned its default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        w_cmd_ready  = 1'b0;
        w_xfer_done  = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            IDLE: begin
                w_cmd_ready = 1'b1;
                if (bus.cmd_valid) w_next_state = SETUP;
            end
            SETUP: w_next_state = ACCESS;
            ACCESS: begin
                if (bus.Pready) begin
                    w_cmd_ready  = 1'b1;
                    w_xfer_done  = 1'b1;
                    w_next_state = bus.cmd_valid ? SETUP : IDLE;
                end else if (w_expired) begin
                    w_timeout    = 1'b1;
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    assign w_cmd_accept = bus.cmd_valid && w_cmd_ready;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge Pclk) begin
        if (Prst) begin
            r_state     <= IDLE;
            r_paddr     <= '0;
            r_pwdata    <= '0;
            r_pwrite    <= 1'b0;
            r_pselx     <= 1'b0;
            r_penable   <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_pselx     <= (w_next_state != IDLE);
            r_penable   <= (w_next_state == ACCESS);
            r_rsp_valid <= w_xfer_done || w_timeout;
            if (w_cmd_accept) begin
                r_paddr  <= bus.cmd_addr;
                r_pwrite <= bus.cmd_write;
                r_pwdata <= bus.cmd_wdata;
            end
            // Response uses r_pwrite before a back-to-back capture replaces it.
            if (w_xfer_done) begin
                r_rsp_err   <= bus.Pslverr;
                r_rsp_rdata <= r_pwrite ? '0 : bus.Prdata;
            end else if (w_timeout) begin
                r_rsp_err   <= 1'b1;
                r_rsp_rdata <= '0;
            end
        end
    end

    assign bus.cmd_ready = w_cmd_ready;
    assign bus.Paddr     = r_paddr;
    assign bus.Pwdata    = r_pwdata;
    assign bus.Pwrite    = r_pwrite;
    assign bus.Pselx     = r_pselx;
    assign bus.Penable   = r_penable;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rsp_rdata;
    assign bus.rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Bench for apb_master_bridge: APB memory slave, transaction-level reference
// model compared every cycle, directed scenarios, then randomized traffic.
`timescale 1ns/1ps
module tb_apb_master_bridge;
    import apb_pkg::*;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
`ifdef APB_TIMEOUT_EN
    localparam int TMO      = 4;
    localparam int MAX_WAIT = 6;
`else
    localparam int TMO      = 16;
    localparam int MAX_WAIT = 3;
`endif

    logic Pclk = 1'b0;
    logic Prst = 1'b1;
    always #5 Pclk = ~Pclk;

    apb_master_bridge_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    apb_master_bridge #(
        .ADDR_W         (ADDR_W),
        .DATA_W         (DATA_W),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .Pclk (Pclk),
        .Prst (Prst),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // APB memory slave: 16 words indexed by address bits [5:2]
    logic [31:0] mem [0:15];
    int wait_left = 0;
    int dir_waits = -1;
    int dir_err   = -1;

    always @(negedge Pclk) begin
        if (bus.Pselx && !bus.Penable)
            wait_left = (dir_waits >= 0) ? dir_waits : int'($urandom_range(MAX_WAIT, 0));
        if (bus.Pselx && bus.Penable) begin
            bus.Pready  = (wait_left == 0);
            if (wait_left > 0) wait_left--;
            bus.Pslverr = (dir_err >= 0) ? (dir_err != 0) : ($urandom_range(7, 0) == 0);
        end else begin
            bus.Pready  = $urandom_range(1, 0) != 0;
            bus.Pslverr = $urandom_range(1, 0) != 0;
        end
        bus.Prdata = mem[bus.Paddr[5:2]];
    end

    // Reference model: one outstanding transfer, tracked as busy / enabled
    typedef struct {
        bit          write;
        logic [31:0] addr;
        logic [31:0] wdata;
    } txn_t;

    txn_t        m_txn;
    bit          m_busy, m_en, model_ok;
    int          m_waits;
    logic        exp_pselx, exp_penable, exp_pwrite, exp_rsp_valid, exp_rsp_err;
    logic [31:0] exp_paddr, exp_pwdata, exp_rdata;

    always @(posedge Pclk) begin
        bit ready_exp, accept, done, abort;
        if (Prst) begin
            m_busy = 0; m_en = 0; m_waits = 0; model_ok = 1;
            m_txn = '{write: 1'b0, addr: '0, wdata: '0};
            exp_rsp_valid = 0; exp_rsp_err = 0; exp_rdata = '0;
        end else if (model_ok) begin
            ready_exp = !m_busy || (m_en && bus.Pready);
            check("cmd_ready", bus.cmd_ready, ready_exp);
            accept = bus.cmd_valid && ready_exp;
            done   = m_en && bus.Pready;
            abort  = 0;
`ifdef APB_TIMEOUT_EN
            if (m_en && !bus.Pready) begin
                m_waits++;
                abort = (m_waits == TMO);
            end
`endif
            exp_rsp_valid = done || abort;
            if (done) begin
                exp_rsp_err = bus.Pslverr;
                exp_rdata   = m_txn.write ? 32'h0 : mem[m_txn.addr[5:2]];
                if (m_txn.write && !bus.Pslverr) mem[m_txn.addr[5:2]] = m_txn.wdata;
            end else if (abort) begin
                exp_rsp_err = 1'b1;
                exp_rdata   = 32'h0;
            end
            if (accept) begin
                m_txn   = '{write: bus.cmd_write, addr: bus.cmd_addr, wdata: bus.cmd_wdata};
                m_busy  = 1; m_en = 0; m_waits = 0;
            end else if (done || abort) begin
                m_busy = 0; m_en = 0;
            end else if (m_busy) begin
                m_en = 1;
            end
        end
        exp_pselx   = m_busy;
        exp_penable = m_en;
        exp_paddr   = m_txn.addr;
        exp_pwrite  = m_txn.write;
        exp_pwdata  = m_txn.wdata;
    end

    always @(negedge Pclk) begin
        if (model_ok) begin
            check("Pselx",     bus.Pselx,     exp_pselx);
            check("Penable",   bus.Penable,   exp_penable);
            check("Paddr",     bus.Paddr,     exp_paddr);
            check("Pwrite",    bus.Pwrite,    exp_pwrite);
            check("Pwdata",    bus.Pwdata,    exp_pwdata);
            check("rsp_valid", bus.rsp_valid, exp_rsp_valid);
            check("rsp_err",   bus.rsp_err,   exp_rsp_err);
            check("rsp_rdata", bus.rsp_rdata, exp_rdata);
        end
    end

    // Random command driver
    bit rand_mode = 0;
    always @(negedge Pclk) begin
        if (rand_mode) begin
            bus.cmd_valid = $urandom_range(3, 0) != 0;
            bus.cmd_write = $urandom_range(1, 0) != 0;
            bus.cmd_addr  = ($urandom() & 32'h0000_FF00) | (32'($urandom_range(15, 0)) << 2);
            bus.cmd_wdata = $urandom();
        end
    end

    // One command; returns latency in cycles from accept to rsp_valid
    task automatic do_txn(input bit wr, input logic [31:0] a, input logic [31:0] d,
                          input int waits, input int err,
                          output int lat, output logic [31:0] rdata, output logic rerr);
        dir_waits = waits;
        dir_err   = err;
        lat       = -1;
        rdata     = 'x;
        rerr      = 'x;
        @(negedge Pclk); #1;
        bus.cmd_valid = 1'b1; bus.cmd_write = wr; bus.cmd_addr = a; bus.cmd_wdata = d;
        @(posedge Pclk);
        for (int k = 1; k <= 40; k++) begin
            @(negedge Pclk); #1;
            bus.cmd_valid = 1'b0;
            if (bus.Pselx) begin
                check("hold_paddr",  bus.Paddr,  a);
                check("hold_pwrite", bus.Pwrite, wr);
                check("hold_pwdata", bus.Pwdata, d);
            end
            if (k >= 1 && k <= waits + 1 && k < 6) check("cmd_ready_busy", bus.cmd_ready, 1'b0);
            if (bus.rsp_valid) begin
                lat = k; rdata = bus.rsp_rdata; rerr = bus.rsp_err;
                break;
            end
        end
        if (lat < 0) check("rsp_bound", 1'b0, 1'b1);
    endtask

    initial begin
        int          lat;
        logic [31:0] rd;
        logic        re;
        int          rsp_at [$];

        for (int i = 0; i < 16; i++) mem[i] = $urandom();
        bus.cmd_valid = 0; bus.cmd_write = 0; bus.cmd_addr = '0; bus.cmd_wdata = '0;
        bus.Pready = 0; bus.Prdata = '0; bus.Pslverr = 0;
        repeat (2) @(posedge Pclk);
        @(negedge Pclk); #1;
        check("reset_pselx",     bus.Pselx,     1'b0);
        check("reset_rsp_rdata", bus.rsp_rdata, 32'h0);
        Prst = 1'b0;
        #1;
        check("idle_cmd_ready", bus.cmd_ready, 1'b1);

        // Zero-wait write, with cycle-by-cycle phase checks
        dir_waits = 0; dir_err = 0;
        @(negedge Pclk); #1;
        bus.cmd_valid = 1; bus.cmd_write = 1; bus.cmd_addr = 32'h04; bus.cmd_wdata = 32'hDEADBEEF;
        @(posedge Pclk);
        @(negedge Pclk); #1;
        bus.cmd_valid = 0;
        check("wr_p1_psel", {bus.Pselx, bus.Penable}, 2'b10);
        @(negedge Pclk); #1;
        check("wr_p2_psel", {bus.Pselx, bus.Penable}, 2'b11);
        @(negedge Pclk); #1;
        check("wr_p3_rsp", {bus.rsp_valid, bus.rsp_err}, 2'b10);
        check("wr_p3_rdata", bus.rsp_rdata, 32'h0);

        do_txn(0, 32'h04, 32'h0, 0, 0, lat, rd, re);
        check("rd_latency", lat, 3);
        check("rd_data",    rd,  32'hDEADBEEF);
        check("rd_err",     re,  1'b0);

        do_txn(1, 32'h10, 32'hA5A50001, 3, 0, lat, rd, re);
        check("wait3_latency", lat, 6);

        // Back-to-back: write 0x08=1 then read 0x08
        dir_waits = 0; dir_err = 0;
        @(negedge Pclk); #1;
        bus.cmd_valid = 1; bus.cmd_write = 1; bus.cmd_addr = 32'h08; bus.cmd_wdata = 32'h1;
        @(posedge Pclk);
        for (int k = 1; k <= 5; k++) begin
            @(negedge Pclk); #1;
            if (k == 1) begin bus.cmd_write = 0; bus.cmd_wdata = 32'h0; end
            if (k == 3) bus.cmd_valid = 0;
            if (k <= 4) begin
                check("b2b_pselx",   bus.Pselx,   1'b1);
                check("b2b_penable", bus.Penable, k[0] ? 1'b0 : 1'b1);
            end
            if (bus.rsp_valid) rsp_at.push_back(k);
            if (k == 5) check("b2b_rdata", bus.rsp_rdata, 32'h1);
        end
        check("b2b_rsp_count", rsp_at.size(), 2);
        if (rsp_at.size() == 2) check("b2b_rsp_gap", rsp_at[1] - rsp_at[0], 2);

        do_txn(0, 32'h08, 32'h0, 0, 1, lat, rd, re);
        check("slverr_err", re,  1'b1);
        check("slverr_lat", lat, 3);

        // Reset during ACCESS aborts without a response
        dir_waits = 5; dir_err = 0;
        @(negedge Pclk); #1;
        bus.cmd_valid = 1; bus.cmd_write = 0; bus.cmd_addr = 32'h0C; bus.cmd_wdata = 32'h0;
        @(posedge Pclk);
        @(negedge Pclk); #1; bus.cmd_valid = 0;
        @(negedge Pclk); #1;
        check("pre_rst_penable", bus.Penable, 1'b1);
        Prst = 1;
        @(negedge Pclk); #1;
        Prst = 0;
        check("rst_bus", {bus.Pselx, bus.Penable, bus.Pwrite, bus.rsp_valid, bus.rsp_err}, 5'b0);
        check("rst_paddr", bus.Paddr, 32'h0);
        check("rst_rdata", bus.rsp_rdata, 32'h0);
        for (int k = 0; k < 4; k++) begin
            @(negedge Pclk); #1;
            check("rst_no_rsp", bus.rsp_valid, 1'b0);
        end

`ifdef APB_TIMEOUT_EN
        do_txn(0, 32'h04, 32'h0, 100, 0, lat, rd, re);
        check("tmo_latency", lat, 6);
        check("tmo_err",     re,  1'b1);
        check("tmo_rdata",   rd,  32'h0);
        check("tmo_pselx",   bus.Pselx, 1'b0);
`endif

        dir_waits = -1; dir_err = -1;
        rand_mode = 1;
        repeat (3000) @(posedge Pclk);
        rand_mode = 0;
        @(negedge Pclk); #1;
        bus.cmd_valid = 0;
        repeat (40) @(posedge Pclk);
        @(negedge Pclk); #1;
        check("drain_idle", bus.Pselx, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
